// File: rtl/clk_div_meter.sv
// clk_div_meter: measures clk_div periods, high time and timeout/range errors in the clk domain.
// Optional period range check is enabled by defining CLK_DIV_METER_RANGE_CHK_EN.
module clk_div_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN         = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int EXP_MIN     = 8,
  parameter int EXP_MAX     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             range_err,
  output logic [CNT_W-1:0] period_sum,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic [CNT_W-1:0] high_sum
);

  localparam int                NPER_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0]  ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONES   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [NPER_W-1:0] LAST_N = NPER_W'(WIN - 1);

  if (WIN < 1) begin : g_bad_win
    $error("clk_div_meter: WIN must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_div_meter: SYNC_STAGES must be >= 2");
  end
  if ((TIMEOUT < 2) || (TIMEOUT > ((2 ** CNT_W) - 1))) begin : g_bad_timeout
    $error("clk_div_meter: TIMEOUT must be >= 2 and fit in CNT_W");
  end
  if (EXP_MIN > EXP_MAX) begin : g_bad_range
    $error("clk_div_meter: EXP_MIN must not exceed EXP_MAX");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == ONES) ? ONES : (a + ONE);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[CNT_W] ? ONES : t[CNT_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_pcnt;
  logic [NPER_W-1:0]      r_nper;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_timeout;
  logic [CNT_W-1:0]       r_sum;
  logic [CNT_W-1:0]       r_min;
  logic [CNT_W-1:0]       r_max;
  logic [CNT_W-1:0]       r_high;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_capture;
  logic                   w_last;
  logic                   w_arm_to;
  logic                   w_meas_to;
  logic                   w_start_ok;

  // synchroniser chain for clk_div plus one-cycle delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_div};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // edge/timeout decode and next-state logic
  always_comb begin
    w_s        = r_sync[SYNC_STAGES-1];
    w_rise     = w_s & ~r_s_d;
    w_start_ok = (r_state == ST_IDLE) && start;
    w_capture  = (r_state == ST_MEAS) && w_rise;
    w_last     = w_capture && (r_nper == LAST_N);
    // ARM holds TIMEOUT cycles (pcnt 0..TIMEOUT-1); MEAS allows a period of exactly TIMEOUT
    w_arm_to   = (r_state == ST_ARM) && !w_rise && (r_pcnt >= (TO_LIM - ONE));
    w_meas_to  = (r_state == ST_MEAS) && !w_rise && (r_pcnt >= TO_LIM);
    w_next     = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_ARM;
        else       w_next = ST_IDLE;
      end
      ST_ARM: begin
        if (w_rise)        w_next = ST_MEAS;
        else if (w_arm_to) w_next = ST_DONE;
        else               w_next = ST_ARM;
      end
      ST_MEAS: begin
        if (w_last || w_meas_to) w_next = ST_DONE;
        else                     w_next = ST_MEAS;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // measurement datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt    <= ZERO;
      r_nper    <= {NPER_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_sum     <= ZERO;
      r_min     <= ZERO;
      r_max     <= ZERO;
      r_high    <= ZERO;
    end else begin
      r_busy <= (w_next == ST_ARM) || (w_next == ST_MEAS);
      r_done <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pcnt    <= ZERO;
            r_nper    <= {NPER_W{1'b0}};
            r_timeout <= 1'b0;
            r_sum     <= ZERO;
            r_min     <= ONES;
            r_max     <= ZERO;
            r_high    <= ZERO;
          end
        end
        ST_ARM: begin
          if (w_rise) begin
            // the first-rise cycle opens the window, so its high sample counts
            r_pcnt <= ONE;
            r_nper <= {NPER_W{1'b0}};
            r_high <= sat_inc(r_high);
          end else if (w_arm_to) begin
            r_timeout <= 1'b1;
            r_min     <= ZERO;
          end else begin
            r_pcnt <= sat_inc(r_pcnt);
          end
        end
        ST_MEAS: begin
          if (w_s && !w_last) begin
            r_high <= sat_inc(r_high);
          end
          if (w_rise) begin
            r_sum  <= sat_add(r_sum, r_pcnt);
            r_nper <= r_nper + NPER_W'(1);
            r_pcnt <= ONE;
            if (r_pcnt < r_min) r_min <= r_pcnt;
            if (r_pcnt > r_max) r_max <= r_pcnt;
          end else if (w_meas_to) begin
            r_timeout <= 1'b1;
            if (r_nper == {NPER_W{1'b0}}) r_min <= ZERO;
          end else begin
            r_pcnt <= sat_inc(r_pcnt);
          end
        end
        ST_DONE: begin
          r_pcnt <= r_pcnt;
        end
        default: begin
          r_pcnt <= ZERO;
        end
      endcase
    end
  end

`ifdef CLK_DIV_METER_RANGE_CHK_EN
  logic r_range_err;

  // sticky out-of-range flag, cleared by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if (w_start_ok) begin
      r_range_err <= 1'b0;
    end else if (w_capture &&
                 ((r_pcnt < CNT_W'(EXP_MIN)) || (r_pcnt > CNT_W'(EXP_MAX)))) begin
      r_range_err <= 1'b1;
    end else begin
      r_range_err <= r_range_err;
    end
  end

  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout;
  assign period_sum  = r_sum;
  assign period_min  = r_min;
  assign period_max  = r_max;
  assign high_sum    = r_high;

endmodule
